// File: rtl/decode_issue_queue_pkg.sv
// Shared layout and helpers for the decode-to-execute issue queue.
// Entries are stored flat: CTRL | RS1 addr | RS2 addr | RS1 data | RS2 data.
package decode_issue_queue_pkg;

  localparam int ZERO_REG = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ctrl_lsb();
    return 0;
  endfunction

  function automatic int rs1a_lsb(input int cw);
    return cw;
  endfunction

  function automatic int rs2a_lsb(input int cw, input int aw);
    return cw + aw;
  endfunction

  function automatic int rs1d_lsb(input int cw, input int aw);
    return cw + 2 * aw;
  endfunction

  function automatic int rs2d_lsb(
    input int cw,
    input int aw,
    input int xl
  );
    return cw + 2 * aw + xl;
  endfunction

  function automatic int entry_width(
    input int cw,
    input int aw,
    input int xl
  );
    return cw + 2 * aw + 2 * xl;
  endfunction

endpackage

// File: rtl/decode_issue_queue_entry.sv
// One queue slot: captured instruction plus write-back snoop on both sources.
// A write takes priority over snooping; a pushed operand forwards WB_DATA.
module decode_queue_entry
  import decode_issue_queue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 64,
  localparam int EW = entry_width(CTRL_WIDTH, REG_ADDR_WIDTH, XLEN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      write,
  input  logic                      consume,
  input  logic [EW-1:0]             write_data,
  input  logic                      wb_enable,
  input  logic [REG_ADDR_WIDTH-1:0] wb_address,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      valid,
  output logic [EW-1:0]             data
);

  localparam int A1 = rs1a_lsb(CTRL_WIDTH);
  localparam int A2 = rs2a_lsb(CTRL_WIDTH, REG_ADDR_WIDTH);
  localparam int D1 = rs1d_lsb(CTRL_WIDTH, REG_ADDR_WIDTH);
  localparam int D2 = rs2d_lsb(CTRL_WIDTH, REG_ADDR_WIDTH, XLEN);
  localparam int AW = REG_ADDR_WIDTH;

  logic          valid_q;
  logic [EW-1:0] data_q;
  logic [EW-1:0] fwd_data;
  logic [EW-1:0] snoop_data;
  logic          wb_live;

  assign wb_live = wb_enable
    && (wb_address != AW'(ZERO_REG));

  always_comb begin
    fwd_data = write_data;
    if (wb_live && wb_address == write_data[A1+:AW])
      fwd_data[D1+:XLEN] = wb_data;
    if (wb_live && wb_address == write_data[A2+:AW])
      fwd_data[D2+:XLEN] = wb_data;
  end

  always_comb begin
    snoop_data = data_q;
    if (wb_live && wb_address == data_q[A1+:AW])
      snoop_data[D1+:XLEN] = wb_data;
    if (wb_live && wb_address == data_q[A2+:AW])
      snoop_data[D2+:XLEN] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (write) begin
      valid_q <= 1'b1;
      data_q  <= fwd_data;
    end else begin
      if (consume) valid_q <= 1'b0;
      if (valid_q && !consume) data_q <= snoop_data;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/decode_issue_queue.sv
// FWFT issue queue between decode and execute with write-back snooping.
// Outputs are zeroed while empty so a bubble behaves as a NOP.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      FLUSH,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [CTRL_WIDTH-1:0]     IN_CTRL,
  input  logic [REG_ADDR_WIDTH-1:0] IN_RS1_ADDRESS,
  input  logic [REG_ADDR_WIDTH-1:0] IN_RS2_ADDRESS,
  input  logic [XLEN-1:0]           IN_RS1_DATA,
  input  logic [XLEN-1:0]           IN_RS2_DATA,
  input  logic                      WB_ENABLE,
  input  logic [REG_ADDR_WIDTH-1:0] WB_ADDRESS,
  input  logic [XLEN-1:0]           WB_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [CTRL_WIDTH-1:0]     OUT_CTRL,
  output logic [REG_ADDR_WIDTH-1:0] OUT_RS1_ADDRESS,
  output logic [REG_ADDR_WIDTH-1:0] OUT_RS2_ADDRESS,
  output logic [XLEN-1:0]           OUT_RS1_DATA,
  output logic [XLEN-1:0]           OUT_RS2_DATA,
  output logic [CW-1:0]             OCCUPANCY
);

  localparam int EW = entry_width(CTRL_WIDTH, REG_ADDR_WIDTH, XLEN);
  localparam int A1 = rs1a_lsb(CTRL_WIDTH);
  localparam int A2 = rs2a_lsb(CTRL_WIDTH, REG_ADDR_WIDTH);
  localparam int D1 = rs1d_lsb(CTRL_WIDTH, REG_ADDR_WIDTH);
  localparam int D2 = rs2d_lsb(CTRL_WIDTH, REG_ADDR_WIDTH, XLEN);
  localparam int C0 = ctrl_lsb();

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [EW-1:0] in_data;
  logic [EW-1:0] head;
  logic [EW-1:0] ent_data [DEPTH];
  logic          ent_valid [DEPTH];

  assign IN_READY  = (count_q != CW'(DEPTH));
  assign not_empty = (count_q != '0) && ent_valid[rptr_q];
  assign OUT_VALID = not_empty;
  assign push      = IN_VALID && IN_READY && !FLUSH;
  assign pop       = not_empty && OUT_READY;
  assign OCCUPANCY = count_q;

  assign in_data = {IN_RS2_DATA, IN_RS1_DATA,
                    IN_RS2_ADDRESS, IN_RS1_ADDRESS,
                    IN_CTRL};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    decode_queue_entry #(
      .XLEN           (XLEN),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .CTRL_WIDTH     (CTRL_WIDTH)
    ) u_entry (
      .clk        (CLK),
      .rst        (RST),
      .clear      (FLUSH),
      .write      (push && wptr_q == PW'(i)),
      .consume    (pop && rptr_q == PW'(i)),
      .write_data (in_data),
      .wb_enable  (WB_ENABLE),
      .wb_address (WB_ADDRESS),
      .wb_data    (WB_DATA),
      .valid      (ent_valid[i]),
      .data       (ent_data[i])
    );
  end

  assign head = not_empty ? ent_data[rptr_q] : '0;

  assign OUT_CTRL        = head[C0+:CTRL_WIDTH];
  assign OUT_RS1_ADDRESS = head[A1+:REG_ADDR_WIDTH];
  assign OUT_RS2_ADDRESS = head[A2+:REG_ADDR_WIDTH];
  assign OUT_RS1_DATA    = head[D1+:XLEN];
  assign OUT_RS2_DATA    = head[D2+:XLEN];

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Randomised and directed checks of decode_issue_queue against a queue model.
module tb_decode_issue_queue;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int CWD = 64;
  localparam int DEPTH = 2;

  typedef struct {
    logic [CWD-1:0] ctrl;
    logic [AW-1:0]  a1;
    logic [AW-1:0]  a2;
    logic [XL-1:0]  d1;
    logic [XL-1:0]  d2;
  } ent_t;

  logic           CLK = 0;
  logic           RST = 0;
  logic           FLUSH = 0;
  logic           IN_VALID = 0;
  logic           IN_READY;
  logic [CWD-1:0] IN_CTRL = 0;
  logic [AW-1:0]  IN_RS1_ADDRESS = 0;
  logic [AW-1:0]  IN_RS2_ADDRESS = 0;
  logic [XL-1:0]  IN_RS1_DATA = 0;
  logic [XL-1:0]  IN_RS2_DATA = 0;
  logic           WB_ENABLE = 0;
  logic [AW-1:0]  WB_ADDRESS = 0;
  logic [XL-1:0]  WB_DATA = 0;
  logic           OUT_VALID;
  logic           OUT_READY = 0;
  logic [CWD-1:0] OUT_CTRL;
  logic [AW-1:0]  OUT_RS1_ADDRESS;
  logic [AW-1:0]  OUT_RS2_ADDRESS;
  logic [XL-1:0]  OUT_RS1_DATA;
  logic [XL-1:0]  OUT_RS2_DATA;
  logic [1:0]     OCCUPANCY;

  int total = 0;
  int bad = 0;
  ent_t q[$];

  decode_issue_queue #(
    .XLEN(XL), .REG_ADDR_WIDTH(AW),
    .CTRL_WIDTH(CWD), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_CTRL(IN_CTRL),
    .IN_RS1_ADDRESS(IN_RS1_ADDRESS),
    .IN_RS2_ADDRESS(IN_RS2_ADDRESS),
    .IN_RS1_DATA(IN_RS1_DATA),
    .IN_RS2_DATA(IN_RS2_DATA),
    .WB_ENABLE(WB_ENABLE), .WB_ADDRESS(WB_ADDRESS),
    .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_CTRL(OUT_CTRL),
    .OUT_RS1_ADDRESS(OUT_RS1_ADDRESS),
    .OUT_RS2_ADDRESS(OUT_RS2_ADDRESS),
    .OUT_RS1_DATA(OUT_RS1_DATA),
    .OUT_RS2_DATA(OUT_RS2_DATA),
    .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [AW-1:0] a);
    return WB_ENABLE && WB_ADDRESS != 0 && WB_ADDRESS == a;
  endfunction

  // Next state from the rules: flush/reset empty it, otherwise
  // snoop every waiting entry, retire the head, append the input.
  task automatic model_step();
    bit rdy, vld, psh, pp;
    ent_t e;
    rdy = q.size() != DEPTH;
    vld = q.size() != 0;
    if (RST || FLUSH) begin
      q.delete();
      return;
    end
    pp  = vld && OUT_READY;
    psh = IN_VALID && rdy;
    if (pp) void'(q.pop_front());
    foreach (q[i]) begin
      if (hit(q[i].a1)) q[i].d1 = WB_DATA;
      if (hit(q[i].a2)) q[i].d2 = WB_DATA;
    end
    if (psh) begin
      e.ctrl = IN_CTRL;
      e.a1 = IN_RS1_ADDRESS;
      e.a2 = IN_RS2_ADDRESS;
      e.d1 = hit(IN_RS1_ADDRESS) ? WB_DATA : IN_RS1_DATA;
      e.d2 = hit(IN_RS2_ADDRESS) ? WB_DATA : IN_RS2_DATA;
      q.push_back(e);
    end
  endtask

  task automatic compare();
    ent_t h;
    h = '{default: '0};
    if (q.size() != 0) h = q[0];
    chk("occupancy", 64'(OCCUPANCY), 64'(q.size()));
    chk("in_ready", 64'(IN_READY), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(OUT_VALID), 64'(q.size() != 0));
    chk("out_ctrl", OUT_CTRL, h.ctrl);
    chk("out_rs1_addr", 64'(OUT_RS1_ADDRESS), 64'(h.a1));
    chk("out_rs2_addr", 64'(OUT_RS2_ADDRESS), 64'(h.a2));
    chk("out_rs1_data", 64'(OUT_RS1_DATA), 64'(h.d1));
    chk("out_rs2_data", 64'(OUT_RS2_DATA), 64'(h.d2));
  endtask

  // Inputs are set at negedge; one clock later outputs are compared.
  task automatic step();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    compare();
  endtask

  task automatic drive(input logic v,
                       input logic [63:0] c,
                       input logic [AW-1:0] a1,
                       input logic [XL-1:0] d1,
                       input logic [AW-1:0] a2,
                       input logic [XL-1:0] d2);
    IN_VALID = v;
    IN_CTRL = c;
    IN_RS1_ADDRESS = a1;
    IN_RS1_DATA = d1;
    IN_RS2_ADDRESS = a2;
    IN_RS2_DATA = d2;
  endtask

  task automatic wb(input logic en,
                    input logic [AW-1:0] a,
                    input logic [XL-1:0] d);
    WB_ENABLE = en;
    WB_ADDRESS = a;
    WB_DATA = d;
  endtask

  initial begin
    @(negedge CLK);
    RST = 1;
    step();
    RST = 0;
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_occ", 64'(OCCUPANCY), 64'd0);
    chk("rst_out_ctrl", OUT_CTRL, 64'd0);

    // single push into empty, execute ready
    OUT_READY = 1;
    drive(1, 64'h10, 5, 32'h11, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("lat_valid", 64'(OUT_VALID), 64'd1);
    chk("lat_rs1", 64'(OUT_RS1_DATA), 64'h11);
    chk("lat_occ1", 64'(OCCUPANCY), 64'd1);
    step();
    chk("lat_occ0", 64'(OCCUPANCY), 64'd0);

    // fill to full, third push is held off
    OUT_READY = 0;
    drive(1, 64'h1, 1, 1, 2, 2);
    step();
    drive(1, 64'h2, 1, 1, 2, 2);
    step();
    chk("full_ready", 64'(IN_READY), 64'd0);
    chk("full_occ", 64'(OCCUPANCY), 64'd2);
    drive(1, 64'h3, 1, 1, 2, 2);
    step();
    chk("full_held", 64'(OCCUPANCY), 64'd2);
    chk("full_head", OUT_CTRL, 64'h1);
    drive(0, 0, 0, 0, 0, 0);
    OUT_READY = 1;
    step();
    chk("drain_ready", 64'(IN_READY), 64'd1);
    chk("drain_order", OUT_CTRL, 64'h2);
    step();
    chk("drain_empty", 64'(OCCUPANCY), 64'd0);

    // stalled head snoops write-back
    OUT_READY = 0;
    drive(1, 64'h4, 0, 0, 7, 32'hAA);
    step();
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 7, 32'hBB);
    step();
    wb(0, 0, 0);
    chk("snoop_rs2", 64'(OUT_RS2_DATA), 64'hBB);
    OUT_READY = 1;
    step();
    OUT_READY = 0;
    drive(1, 64'h5, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    wb(1, 0, 32'h55);
    step();
    wb(0, 0, 0);
    chk("snoop_x0", 64'(OUT_RS2_DATA), 64'h0);
    OUT_READY = 1;
    step();

    // push-cycle forwarding
    OUT_READY = 0;
    drive(1, 64'h6, 3, 32'h1, 0, 0);
    wb(1, 3, 32'h99);
    step();
    drive(0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    chk("push_fwd", 64'(OUT_RS1_DATA), 64'h99);
    OUT_READY = 1;
    step();

    // flush a full queue with a push pending
    OUT_READY = 0;
    drive(1, 64'h7, 1, 1, 1, 1);
    step();
    step();
    chk("pre_flush_occ", 64'(OCCUPANCY), 64'd2);
    FLUSH = 1;
    drive(1, 64'hDEAD, 9, 9, 9, 9);
    step();
    FLUSH = 0;
    drive(0, 0, 0, 0, 0, 0);
    chk("flush_occ", 64'(OCCUPANCY), 64'd0);
    chk("flush_valid", 64'(OUT_VALID), 64'd0);
    chk("flush_ctrl", OUT_CTRL, 64'd0);
    OUT_READY = 1;
    step();
    chk("flush_dropped", 64'(OUT_VALID), 64'd0);

    // reset mid-stream with write-back active
    OUT_READY = 0;
    drive(1, 64'h8, 4, 4, 4, 4);
    step();
    drive(0, 0, 0, 0, 0, 0);
    RST = 1;
    wb(1, 4, 32'h77);
    step();
    RST = 0;
    wb(0, 0, 0);
    chk("rst2_valid", 64'(OUT_VALID), 64'd0);
    chk("rst2_occ", 64'(OCCUPANCY), 64'd0);
    chk("rst2_rs1", 64'(OUT_RS1_DATA), 64'd0);
    chk("rst2_ready", 64'(IN_READY), 64'd1);

    // randomised traffic
    for (int n = 0; n < 4000; n++) begin
      RST = ($urandom_range(0, 199) == 0);
      FLUSH = ($urandom_range(0, 39) == 0);
      OUT_READY = $urandom_range(0, 1);
      drive($urandom_range(0, 9) < 6,
            {$urandom, $urandom},
            AW'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 7)), $urandom);
      wb($urandom_range(0, 1),
         AW'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
